// File: rtl/clock_divide_pkg.sv
// clock_divide_pkg
//   Shared definitions for the multi-channel clock divider bank.
//   - DEF_CHANNELS / DEF_DIV_W / DEF_PH_W : default bank geometry
//   - CNT_W                               : counter width for the default ratio width
//   - chan_out_t                          : per-channel decoded outputs
//   - div_period / div_preload            : period and phase-preload arithmetic
package clock_divide_pkg;

    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_DIV_W    = 4;
    localparam int unsigned DEF_PH_W     = 5;
    localparam int unsigned CNT_W        = DEF_DIV_W + 1;

    typedef struct packed {
        logic clk_p;
        logic clk_n;
        logic tick;
        logic aligned;
    } chan_out_t;

    // Period in input cycles for ratio field r: P = 2*(r+1).
    function automatic int unsigned div_period(input int unsigned ratio);
        return 2 * (ratio + 1);
    endfunction

    // Counter preload for a ratio/phase pair. The phase saturates at P-1
    // rather than wrapping, so a channel with phase k rises k cycles after
    // a phase-0 channel loaded on the same edge.
    function automatic int unsigned div_preload(input int unsigned ratio,
                                                input int unsigned phase);
        int unsigned p;
        int unsigned eph;
        p   = div_period(ratio);
        eph = (phase > p - 1) ? p - 1 : phase;
        return (p - eph) % p;
    endfunction

endpackage

// File: rtl/clock_divide_channel.sv
// clock_divide_channel
//   One 50%-duty divider channel: counter, applied ratio/phase registers,
//   pending-update flags and output decode.
//   Ports:
//     in_clk_p  : clock (rising edge)
//     reset     : synchronous active-high reset; reloads from cfg
//     sync      : realign strobe (already gated by the bank)
//     cfg_ratio : configured ratio field r
//     cfg_phase : configured phase field ph
//     out       : decoded clk_p / clk_n / tick / aligned
module clock_divide_channel
    import clock_divide_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned PH_W  = DEF_PH_W
) (
    input  logic             in_clk_p,
    input  logic             reset,
    input  logic             sync,
    input  logic [DIV_W-1:0] cfg_ratio,
    input  logic [PH_W-1:0]  cfg_phase,
    output chan_out_t        out
);

    localparam int unsigned CH_CNT_W = DIV_W + 1;

    logic                run;
    logic [CH_CNT_W-1:0] cnt;
    logic [DIV_W-1:0]    a_ratio;
    logic [PH_W-1:0]     a_phase;
    logic                pend_r;
    logic                pend_p;

    logic [CH_CNT_W-1:0] half;
    logic [CH_CNT_W-1:0] last;
    logic [CH_CNT_W-1:0] cfg_preload;
    logic                wrap;
    int unsigned         pre_full;

    always_comb begin
        half        = {1'b0, a_ratio} + CH_CNT_W'(1);
        // P-1 = 2*r+1, i.e. the ratio with a trailing one.
        last        = {a_ratio, 1'b1};
        wrap        = (cnt == last);
        pre_full    = div_preload(32'(cfg_ratio), 32'(cfg_phase));
        cfg_preload = pre_full[CH_CNT_W-1:0];
    end

    always_ff @(posedge in_clk_p) begin
        if (reset) begin
            run     <= 1'b0;
            a_ratio <= cfg_ratio;
            a_phase <= cfg_phase;
            cnt     <= cfg_preload;
            pend_r  <= 1'b0;
            pend_p  <= 1'b0;
        end else if (sync) begin
            run     <= 1'b1;
            a_ratio <= cfg_ratio;
            a_phase <= cfg_phase;
            cnt     <= cfg_preload;
            pend_r  <= 1'b0;
            pend_p  <= 1'b0;
        end else begin
            run    <= 1'b1;
            // Pending flags are sticky until the matching update is applied.
            pend_p <= pend_p | (cfg_phase != a_phase);
            pend_r <= pend_r | (cfg_ratio != a_ratio);
            // The counter holds its preload on the first edge after reset so
            // the outputs start exactly at the preloaded position.
            if (run) begin
                if (wrap) begin
                    cnt <= '0;
                    if (pend_r) begin
                        // Old period has fully completed: switch ratio here.
                        a_ratio <= cfg_ratio;
                        pend_r  <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CH_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        out.clk_p   = run & (cnt <  half);
        out.clk_n   = run & (cnt >= half);
        out.tick    = run & (cnt == '0);
        out.aligned = run & ~pend_r & ~pend_p;
    end

endmodule

// File: rtl/clock_divide_bank.sv
// clock_divide_bank
//   Multi-channel programmable clock divider with per-channel phase offset,
//   glitch-free ratio changes at period boundaries and a common realign strobe.
//   Optional feature macro: CLK_DIV_SYNC_EN (sync_in functional when defined;
//   otherwise sync_in is ignored and phase is applied only at reset).
//   Ports:
//     in_clk_p    : clock (rising edge)
//     reset       : synchronous active-high reset
//     cfg_ratio   : CHANNELS x DIV_W ratio fields, channel i at [i*DIV_W +: DIV_W]
//     cfg_phase   : CHANNELS x PH_W phase fields, channel i at [i*PH_W +: PH_W]
//     sync_in     : realign strobe
//     out_clk_p   : divided clocks
//     out_clk_n   : complements of out_clk_p while running
//     out_tick    : one-cycle pulse at each period start
//     out_aligned : applied ratio/phase match the configuration
module clock_divide_bank
    import clock_divide_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DIV_W    = DEF_DIV_W,
    parameter int unsigned PH_W     = DEF_PH_W
) (
    input  logic                      in_clk_p,
    input  logic                      reset,
    input  logic [CHANNELS*DIV_W-1:0] cfg_ratio,
    input  logic [CHANNELS*PH_W-1:0]  cfg_phase,
    input  logic                      sync_in,
    output logic [CHANNELS-1:0]       out_clk_p,
    output logic [CHANNELS-1:0]       out_clk_n,
    output logic [CHANNELS-1:0]       out_tick,
    output logic [CHANNELS-1:0]       out_aligned
);

    logic sync_eff;

`ifdef CLK_DIV_SYNC_EN
    assign sync_eff = sync_in;
`else
    // Port kept for interface compatibility; the strobe has no effect.
    assign sync_eff = 1'b0 & sync_in;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        chan_out_t ch_out;

        clock_divide_channel #(
            .DIV_W (DIV_W),
            .PH_W  (PH_W)
        ) u_ch (
            .in_clk_p  (in_clk_p),
            .reset     (reset),
            .sync      (sync_eff),
            .cfg_ratio (cfg_ratio[i*DIV_W +: DIV_W]),
            .cfg_phase (cfg_phase[i*PH_W +: PH_W]),
            .out       (ch_out)
        );

        assign out_clk_p[i]   = ch_out.clk_p;
        assign out_clk_n[i]   = ch_out.clk_n;
        assign out_tick[i]    = ch_out.tick;
        assign out_aligned[i] = ch_out.aligned;
    end

endmodule
